// File: rtl/demux_pkg.sv
// Shared types for the 1-to-2 stream demultiplexer.
package demux_pkg;

    localparam int DEMUX_DW = 24;

    typedef logic [DEMUX_DW-1:0] word_t;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

    typedef enum logic {
        CH0 = 1'b0,
        CH1 = 1'b1
    } chan_t;

endpackage

// File: rtl/demux_out_slot.sv
// One-entry registered output slot of the stream demultiplexer.
// Optional delivered-word counter when DEMUX_STATS_EN is defined.
//
//  state      | meaning
//  -----------+--------------------------------------------------
//  SLOT_EMPTY | no word held, out_valid=0, slot can always load
//  SLOT_FULL  | word held on out_data, out_valid=1 until drained
module demux_out_slot
    import demux_pkg::*;
#(
    parameter int DW = DEMUX_DW
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [DW-1:0] load_data,
    output logic          slot_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt
`endif
);

    slot_state_t   state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic          drain;

    assign out_valid  = (state_q == SLOT_FULL);
    assign out_data   = data_q;
    assign drain      = out_valid & out_ready;
    // A word leaving this cycle frees the slot for a same-cycle load.
    assign slot_ready = (state_q == SLOT_EMPTY) | out_ready;

    // Next-state and next-data: a load always wins, a bare drain empties the slot.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load) begin
            state_d = SLOT_FULL;
            data_d  = load_data;
        end else if (drain) begin
            state_d = SLOT_EMPTY;
        end
    end

    // Slot state and held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLOT_EMPTY;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign cnt = cnt_q;

    // Delivered-word count, wraps naturally at full scale.
    always_comb begin
        cnt_d = cnt_q;
        if (drain) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`endif

endmodule

// File: rtl/demux1to2_stream.sv
// 1-to-2 stream demultiplexer: steers each accepted input word to output 0
// or 1 by in_sel. Each output has its own one-entry slot so a stalled
// consumer never blocks the other channel.
// Define DEMUX_STATS_EN to add per-channel delivered-word counters cnt0/cnt1.
module demux1to2_stream
    import demux_pkg::*;
#(
    parameter int DW = DEMUX_DW
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W = 16
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic          in_sel,
    output logic          out0_valid,
    input  logic          out0_ready,
    output logic [DW-1:0] out0_data,
    output logic          out1_valid,
    input  logic          out1_ready,
    output logic [DW-1:0] out1_data
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1
`endif
);

    chan_t sel_ch;
    logic  slot0_ready;
    logic  slot1_ready;
    logic  accept;
    logic  load0;
    logic  load1;

    assign sel_ch = chan_t'(in_sel);

    // Only the selected slot decides readiness; the other slot is irrelevant.
    always_comb begin
        in_ready = slot0_ready;
        if (sel_ch == CH1) begin
            in_ready = slot1_ready;
        end
    end

    assign accept = in_valid & in_ready;
    assign load0  = accept & (sel_ch == CH0);
    assign load1  = accept & (sel_ch == CH1);

    demux_out_slot #(
        .DW    (DW)
`ifdef DEMUX_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_slot0 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load0),
        .load_data  (in_data),
        .slot_ready (slot0_ready),
        .out_valid  (out0_valid),
        .out_ready  (out0_ready),
        .out_data   (out0_data)
`ifdef DEMUX_STATS_EN
        ,
        .cnt        (cnt0)
`endif
    );

    demux_out_slot #(
        .DW    (DW)
`ifdef DEMUX_STATS_EN
        ,
        .CNT_W (CNT_W)
`endif
    ) u_slot1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load1),
        .load_data  (in_data),
        .slot_ready (slot1_ready),
        .out_valid  (out1_valid),
        .out_ready  (out1_ready),
        .out_data   (out1_data)
`ifdef DEMUX_STATS_EN
        ,
        .cnt        (cnt1)
`endif
    );

endmodule
